// File: rtl/vram_pkg.sv
// Shared types for the video RAM arbiter: port owner encoding and
// default RAM geometry (bank + 13-bit offset, byte wide).
package vram_pkg;

    localparam int VRAM_AW = 15;
    localparam int VRAM_DW = 8;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_CPU,
        OWN_DMA
    } owner_t;

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational owner selector for the VRAM port.
// VRAM_ARB_RECLAIM_EN lets CPU/DMA reuse video slots during blanking.
module vram_arb_pick
    import vram_pkg::*;
(
    input  logic   slot_vid,
    input  logic   vid_en,
    input  logic   cpu_req,
    input  logic   dma_req,
    input  logic   starved,
    output owner_t owner,
    output logic   shared
);

`ifdef VRAM_ARB_RECLAIM_EN
    assign shared = !slot_vid || !vid_en;
`else
    logic unused_vid_en;
    assign unused_vid_en = vid_en;
    assign shared = !slot_vid;
`endif

    always_comb begin
        owner = OWN_NONE;
        if (!shared) begin
            owner = OWN_VID;
        end else if (starved && dma_req) begin
            owner = OWN_DMA;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end else if (dma_req) begin
            owner = OWN_DMA;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Time-slot arbiter for the single VRAM port (clk_2x domain).
// Optional blanking-slot reclaim under VRAM_ARB_RECLAIM_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW         = VRAM_AW,
    parameter int DW         = VRAM_DW,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          slot_vid,
    input  logic          vid_en,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_rvalid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_dout,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_din,
    output logic          dma_ack,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_dout,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    owner_t        owner;
    owner_t        owner_d;
    logic          shared;
    logic          starved;
    logic          we_d;
    logic          wr;
    logic [CW-1:0] starve_cnt;
    logic [DW-1:0] cpu_hold;
    logic [DW-1:0] dma_hold;

    assign starved = (starve_cnt == LIM);

    vram_arb_pick u_pick (
        .slot_vid (slot_vid),
        .vid_en   (vid_en),
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .starved  (starved),
        .owner    (owner),
        .shared   (shared)
    );

    // Idle port keeps the raster address so the RAM sees a stable bus.
    always_comb begin
        mem_addr = vid_addr;
        mem_din  = '0;
        wr       = 1'b0;
        unique case (owner)
            OWN_CPU: begin
                mem_addr = cpu_addr;
                mem_din  = cpu_din;
                wr       = cpu_we;
            end
            OWN_DMA: begin
                mem_addr = dma_addr;
                mem_din  = dma_din;
                wr       = dma_we;
            end
            default: ;
        endcase
    end

    assign mem_we  = wr & ~reset;
    assign cpu_ack = (owner == OWN_CPU) & ~reset;
    assign dma_ack = (owner == OWN_DMA) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_d <= OWN_NONE;
            we_d    <= 1'b0;
        end else begin
            owner_d <= owner;
            we_d    <= mem_we;
        end
    end

    assign vid_rvalid = ~reset & (owner_d == OWN_VID) & ~we_d;
    assign cpu_rvalid = ~reset & (owner_d == OWN_CPU) & ~we_d;
    assign dma_rvalid = ~reset & (owner_d == OWN_DMA) & ~we_d;

    // Read data is presented with rvalid, then held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_hold <= '0;
            dma_hold <= '0;
        end else begin
            if (cpu_rvalid) cpu_hold <= mem_dout;
            if (dma_rvalid) dma_hold <= mem_dout;
        end
    end

    assign cpu_dout = reset ? '0
                    : cpu_rvalid ? mem_dout : cpu_hold;
    assign dma_dout = reset ? '0
                    : dma_rvalid ? mem_dout : dma_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (shared) begin
            if (dma_req && owner != OWN_DMA) begin
                if (!starved) starve_cnt <= starve_cnt + CW'(1);
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed, table-driven bench for vram_arbiter with a byte RAM model.
// Expectations follow VRAM_ARB_RECLAIM_EN when it is defined.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        slot_vid;
    logic        vid_en;
    logic [14:0] vid_addr;
    logic        vid_rvalid;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic        cpu_rvalid;
    logic [7:0]  cpu_dout;
    logic        dma_req;
    logic        dma_we;
    logic [14:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_ack;
    logic        dma_rvalid;
    logic [7:0]  dma_dout;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;

    logic [7:0]  ram [0:32767];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    vram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .slot_vid   (slot_vid),
        .vid_en     (vid_en),
        .vid_addr   (vid_addr),
        .vid_rvalid (vid_rvalid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .cpu_dout   (cpu_dout),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_din    (dma_din),
        .dma_ack    (dma_ack),
        .dma_rvalid (dma_rvalid),
        .dma_dout   (dma_dout),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    typedef struct {
        logic        sv, ven, creq, cwe, dreq, dwe;
        logic        cack, dack, mwe;
        logic [14:0] addr;
        logic        vrv, crv, drv;
        logic [7:0]  cdo, ddo;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic creq,
                         input logic cwe, input logic dreq);
        @(negedge clk);
        slot_vid = sv;
        cpu_req  = creq;
        cpu_we   = cwe;
        dma_req  = dreq;
        dma_we   = 1'b0;
        #3;
    endtask

    bit reclaim;

    initial begin
`ifdef VRAM_ARB_RECLAIM_EN
        reclaim = 1'b1;
`else
        reclaim = 1'b0;
`endif
        //          sv ven cr cw dr dw ca da mw addr      vr cr dr cdo    ddo
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0123, 0, 0, 0, 8'h00, 8'h00};
        tbl[1]  = '{0, 1, 1, 1, 0, 0, 1, 0, 1, 15'h1400, 1, 0, 0, 8'h00, 8'h00};
        tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0123, 0, 0, 0, 8'h00, 8'h00};
        tbl[3]  = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 15'h1400, 1, 0, 0, 8'h00, 8'h00};
        tbl[4]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0123, 0, 1, 0, 8'hA5, 8'h00};
        tbl[5]  = '{0, 1, 0, 0, 1, 1, 0, 1, 1, 15'h2222, 1, 0, 0, 8'hA5, 8'h00};
        tbl[6]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0123, 0, 0, 0, 8'hA5, 8'h00};
        tbl[7]  = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 15'h2222, 1, 0, 0, 8'hA5, 8'h00};
        tbl[8]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0123, 0, 0, 1, 8'hA5, 8'h3C};
        tbl[9]  = '{0, 1, 1, 0, 1, 0, 1, 0, 0, 15'h1400, 1, 0, 0, 8'hA5, 8'h3C};
        tbl[10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0123, 0, 1, 0, 8'hA5, 8'h3C};
        tbl[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0123, 1, 0, 0, 8'hA5, 8'h3C};
        tbl[12] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0123, 0, 0, 0, 8'hA5, 8'h3C};

        reset    = 1'b1;
        slot_vid = 1'b0;
        vid_en   = 1'b1;
        vid_addr = 15'h0123;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 15'h1400;
        cpu_din  = 8'hA5;
        dma_req  = 1'b0;
        dma_we   = 1'b0;
        dma_addr = 15'h2222;
        dma_din  = 8'h3C;

        repeat (2) @(negedge clk);
        cpu_req = 1'b1;
        cpu_we  = 1'b1;
        #3;
        chk("rst.mem_we", 32'(mem_we), 0);
        chk("rst.cpu_ack", 32'(cpu_ack), 0);
        chk("rst.cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("rst.dma_rvalid", 32'(dma_rvalid), 0);
        chk("rst.cpu_dout", 32'(cpu_dout), 0);
        chk("rst.dma_dout", 32'(dma_dout), 0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            reset    = 1'b0;
            slot_vid = tbl[i].sv;
            vid_en   = tbl[i].ven;
            cpu_req  = tbl[i].creq;
            cpu_we   = tbl[i].cwe;
            dma_req  = tbl[i].dreq;
            dma_we   = tbl[i].dwe;
            #3;
            chk($sformatf("v%0d.cpu_ack", i), 32'(cpu_ack), 32'(tbl[i].cack));
            chk($sformatf("v%0d.dma_ack", i), 32'(dma_ack), 32'(tbl[i].dack));
            chk($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(tbl[i].mwe));
            chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            chk($sformatf("v%0d.vid_rvalid", i), 32'(vid_rvalid), 32'(tbl[i].vrv));
            chk($sformatf("v%0d.cpu_rvalid", i), 32'(cpu_rvalid), 32'(tbl[i].crv));
            chk($sformatf("v%0d.dma_rvalid", i), 32'(dma_rvalid), 32'(tbl[i].drv));
            chk($sformatf("v%0d.cpu_dout", i), 32'(cpu_dout), 32'(tbl[i].cdo));
            chk($sformatf("v%0d.dma_dout", i), 32'(dma_dout), 32'(tbl[i].ddo));
            if (tbl[i].mwe)
                chk($sformatf("v%0d.mem_din", i), 32'(mem_din),
                    tbl[i].cack ? 32'h0A5 : 32'h03C);
        end

        // Contention: CPU four odd slots, then DMA, repeating.
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            chk($sformatf("ct%0d.cpu_ack", k), 32'(cpu_ack),
                32'((k % 5) != 4));
            chk($sformatf("ct%0d.dma_ack", k), 32'(dma_ack),
                32'((k % 5) == 4));
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            chk($sformatf("ct%0d.vid_slot", k), 32'(mem_addr), 32'h0123);
        end

        // Build starvation to 2, then reset during a CPU write grant.
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            drive(1'b1, 1'b1, 1'b0, 1'b1);
        end
        cpu_din = 8'h77;
        @(negedge clk);
        reset = 1'b1;
        slot_vid = 1'b0;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        dma_req = 1'b1;
        #3;
        chk("rg.mem_we", 32'(mem_we), 0);
        chk("rg.cpu_ack", 32'(cpu_ack), 0);
        chk("rg.dma_ack", 32'(dma_ack), 0);
        chk("rg.cpu_dout", 32'(cpu_dout), 0);
        @(negedge clk);
        reset = 1'b0;
        slot_vid = 1'b1;
        #3;
        chk("rg.post.cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("rg.post.vid_rvalid", 32'(vid_rvalid), 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        chk("rg.regrant.ack", 32'(cpu_ack), 1);
        chk("rg.regrant.we", 32'(mem_we), 1);
        chk("rg.regrant.din", 32'(mem_din), 32'h77);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("rg.wr.no_rvalid", 32'(cpu_rvalid), 0);
        for (int k = 1; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            chk($sformatf("rg%0d.cpu_ack", k), 32'(cpu_ack), 32'(k != 4));
            chk($sformatf("rg%0d.dma_ack", k), 32'(dma_ack), 32'(k == 4));
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            if (k == 1) begin
                chk("rg.rd.rvalid", 32'(cpu_rvalid), 1);
                chk("rg.rd.dout", 32'(cpu_dout), 32'h77);
            end
        end

        // Blanking: DMA alone; video slots reclaimed only with the feature.
        vid_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'((k % 2) == 1), 1'b0, 1'b0, 1'b1);
            chk($sformatf("bl%0d.dma_ack", k), 32'(dma_ack),
                32'((k % 2) == 0 || reclaim));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
